wts_slot_bus_if: RTL
====================

Name: wts_slot_bus_if

Overview:
Parametrised slot-bus front-end for the wave table sound core, replacing the fixed cartridge glue.
- Synchronises asynchronous slot strobes and generates single-cycle write/read requests to the core.
- Runs a read handshake that holds data on the bus for the whole read strobe, with a timeout fallback.
- Drives the open-collector interrupt and produces registered stereo/mono audio of configurable width.

Parameters:
- ADDR_W, 16, slot address width passed to core.
- SYNC_STAGES, 2, flip-flops per strobe synchroniser (min 2).
- RD_TIMEOUT, 15, cycles to wait for core q_valid before returning 8'hFF.
- IN_W, 12, core audio sample width per channel (unsigned).
- OUT_W, 12, output audio width (OUT_W <= IN_W+1).

Ports:
- clk  in  1  system clock, 21.47727 MHz.
- reset  in  1  synchronous, active-high.
- slot_nsltsl  in  1  slot select, active low, async.
- slot_nmerq  in  1  memory request, active low, async.
- slot_nrd  in  1  read strobe, active low, async.
- slot_nwr  in  1  write strobe, active low, async.
- slot_a  in  ADDR_W  slot address.
- slot_d_in  in  8  slot data in.
- slot_d_out  out  8  read data to slot.
- slot_d_oe  out  1  tri-state enable for slot_d (top-level pad drives when 1).
- slot_nint_oe  out  1  1 = pull slot_nint low; 0 = release (hi-Z).
- core_wrreq  out  1  one-cycle write request.
- core_rdreq  out  1  one-cycle read request.
- core_a  out  ADDR_W  latched address.
- core_d  out  8  latched write data.
- core_q  in  8  core read data.
- core_q_valid  in  1  core_q valid this cycle.
- core_nint  in  1  core interrupt, active low.
- sw_mono  in  1  1 = mono mix.
- left_in, right_in  in  IN_W  core audio.
- left_out, right_out  out  OUT_W  registered audio.

Behaviour:
- Reset values: all outputs 0; slot_d_out = 8'h00; FSM in IDLE; synchronisers preset to 1 (inactive).
- Synchronisers: nsltsl, nmerq, nrd and nwr each pass through SYNC_STAGES flops. slot_a and slot_d_in are sampled in the same cycle as the request edge; they are stable on the bus by then.
- Access condition: acc = synced !nsltsl & !nmerq.
- Request edges:
  - Write: synced nwr 1→0 while acc → core_wrreq = 1 for exactly one cycle, with core_a = slot_a and core_d = slot_d_in latched that cycle.
  - Read: synced nrd 1→0 while acc → core_rdreq = 1 for one cycle, with core_a latched.
  - Simultaneous nrd and nwr falling edges (illegal bus state): write wins, read is ignored.
- FSM states: IDLE, RD_WAIT, RD_DRIVE, WAIT_END.
  - IDLE: on a read edge → RD_WAIT with the timer cleared. On a write edge → WAIT_END.
  - RD_WAIT: timer increments each cycle. On core_q_valid, capture core_q into slot_d_out → RD_DRIVE. On timer == RD_TIMEOUT, slot_d_out = 8'hFF → RD_DRIVE. If synced nrd rises or acc drops first → IDLE, nothing driven.
  - RD_DRIVE: slot_d_oe = 1 while acc & !nrd (synced). When nrd rises or acc drops: slot_d_oe = 0 in the same cycle → IDLE.
  - WAIT_END: no new request until synced nwr and nrd are both 1 → IDLE. Guarantees one request per strobe.
- slot_d_oe is 1 only in RD_DRIVE; it is never asserted outside a selected read.
- Interrupt: slot_nint_oe = registered !core_nint, one-cycle latency.
- Audio, registered, one cycle from input:
  - Stereo: out = in[IN_W-1 -: OUT_W] when OUT_W <= IN_W.
  - Mono: sum = {1'b0,left_in} + {1'b0,right_in} (IN_W+1 bits); both outputs = sum[IN_W -: OUT_W]. No overflow is possible.
  - OUT_W == IN_W+1 in stereo: in is zero-extended on the LSB side.
- Reset mid-access: FSM → IDLE, oe released, no request issued; a strobe still low after reset generates no request until it rises and falls again (synchronisers preset high handle this).

Optional Feature:
WTS_SLOT_DEGLITCH_EN
- Defined: a strobe edge is accepted only if the synced strobe level is stable for 2 consecutive cycles after the transition. Request latency +1 cycle; a single-cycle glitch yields no request.
- Undefined: a single synced transition is accepted.

Decomposition:
- Shared package wts_pkg: FSM state enum, RD_TIMEOUT_DEFAULT, DATA_W = 8, the 8'hFF open-bus constant.
- One sub-module wts_sync_edge: N-stage synchroniser with preset-high reset, falling/rising edge pulses and optional deglitch. Instanced once per strobe.

Test Plan:
- Write at a = 16'h9800, d = 8'h5A, nwr low 10 cycles → exactly one core_wrreq, SYNC_STAGES+1 cycles after the fall; core_a = 9800, core_d = 5A.
- Read with core_q_valid 3 cycles after core_rdreq, core_q = 8'hC3 → slot_d_oe = 1 with slot_d_out = C3 until nrd rises; oe = 0 in the same cycle as the synced rise.
- Read with no core_q_valid → slot_d_out = FF after RD_TIMEOUT cycles; oe held until nrd rises.
- nrd and nwr fall together with the slot selected → one core_wrreq, no core_rdreq, slot_d_oe stays 0.
- sw_mono = 1, left_in = 12'hFFF, right_in = 12'h001, OUT_W = 12 → both outputs 12'h800; sw_mono = 0 → left FFF, right 001.
- reset asserted during RD_DRIVE → slot_d_oe = 0 next cycle; nrd still low after reset release → no core_rdreq.

Source files
------------

// File: rtl/wts_pkg.sv
// Shared definitions for the wave table sound slot-bus front-end.
// The optional strobe deglitch filter is enabled with WTS_SLOT_DEGLITCH_EN.
package wts_pkg;

    localparam int DATA_W             = 8;
    localparam int RD_TIMEOUT_DEFAULT = 15;

    // Value returned to the slot when the core never answers a read.
    localparam logic [DATA_W-1:0] OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_DRIVE,
        ST_WAIT_END
    } wts_state_e;

endpackage

// File: rtl/wts_sync_edge.sv
// Preset-high strobe synchroniser with falling-edge detection.
// With WTS_SLOT_DEGLITCH_EN defined, a new level must persist two cycles before it is accepted.
module wts_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   r_live;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // r_live marks that both w_sync and r_prev hold real pin samples, so a strobe
    // held low across reset never looks like a fresh edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '1;
            r_fill <= '0;
            r_prev <= 1'b1;
            r_live <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev <= w_sync;
            r_live <= r_fill[SYNC_STAGES-1];
        end
    end

`ifdef WTS_SLOT_DEGLITCH_EN
    logic r_filt;
    logic w_accept;

    assign w_accept = r_live & (w_sync == r_prev) & (w_sync != r_filt);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_filt <= 1'b1;
        end else if (!r_live) begin
            r_filt <= w_sync;
        end else if (w_accept) begin
            r_filt <= w_sync;
        end
    end

    assign o_level = w_accept ? w_sync : r_filt;
    assign o_fall  = w_accept & ~w_sync;
`else
    assign o_level = w_sync;
    assign o_fall  = r_live & r_prev & ~w_sync;
`endif

endmodule

// File: rtl/wts_slot_bus_if.sv
// Slot-bus front-end: strobe sync, single-cycle core requests, read handshake, IRQ and audio.
// Optional strobe deglitch filter: define WTS_SLOT_DEGLITCH_EN.
module wts_slot_bus_if
    import wts_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RD_TIMEOUT  = RD_TIMEOUT_DEFAULT,
    parameter int IN_W        = 12,
    parameter int OUT_W       = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slot_nsltsl,
    input  logic              slot_nmerq,
    input  logic              slot_nrd,
    input  logic              slot_nwr,
    input  logic [ADDR_W-1:0] slot_a,
    input  logic [DATA_W-1:0] slot_d_in,
    output logic [DATA_W-1:0] slot_d_out,
    output logic              slot_d_oe,
    output logic              slot_nint_oe,
    output logic              core_wrreq,
    output logic              core_rdreq,
    output logic [ADDR_W-1:0] core_a,
    output logic [DATA_W-1:0] core_d,
    input  logic [DATA_W-1:0] core_q,
    input  logic              core_q_valid,
    input  logic              core_nint,
    input  logic              sw_mono,
    input  logic [IN_W-1:0]   left_in,
    input  logic [IN_W-1:0]   right_in,
    output logic [OUT_W-1:0]  left_out,
    output logic [OUT_W-1:0]  right_out
);

    localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

    // Top OUT_W bits of an (IN_W+1)-bit value; stereo feeds {in,0}, mono feeds l+r.
    function automatic logic [OUT_W-1:0] f_scale(input logic [IN_W:0] i_v);
        return OUT_W'(i_v >> (IN_W + 1 - OUT_W));
    endfunction

    wts_state_e          r_state;
    logic [TMR_W-1:0]    r_timer;
    logic                r_wrreq;
    logic                r_rdreq;
    logic [ADDR_W-1:0]   r_core_a;
    logic [DATA_W-1:0]   r_core_d;
    logic [DATA_W-1:0]   r_d_out;
    logic                r_nint_oe;
    logic [OUT_W-1:0]    r_left;
    logic [OUT_W-1:0]    r_right;

    logic w_sltsl_lvl, w_merq_lvl, w_nrd_lvl, w_nwr_lvl;
    logic w_sltsl_fall, w_merq_fall, w_nrd_fall, w_nwr_fall;
    logic w_acc, w_wr_edge, w_rd_edge, w_rd_abort;
    logic w_unused_falls;
    logic [IN_W:0] w_mix;

    wts_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sltsl (
        .i_clk(clk), .i_reset(reset), .i_async(slot_nsltsl), .o_level(w_sltsl_lvl), .o_fall(w_sltsl_fall)
    );
    wts_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_merq (
        .i_clk(clk), .i_reset(reset), .i_async(slot_nmerq), .o_level(w_merq_lvl), .o_fall(w_merq_fall)
    );
    wts_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nrd (
        .i_clk(clk), .i_reset(reset), .i_async(slot_nrd), .o_level(w_nrd_lvl), .o_fall(w_nrd_fall)
    );
    wts_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nwr (
        .i_clk(clk), .i_reset(reset), .i_async(slot_nwr), .o_level(w_nwr_lvl), .o_fall(w_nwr_fall)
    );

    // Select/merq only matter as levels.
    assign w_unused_falls = w_sltsl_fall ^ w_merq_fall;

    assign w_acc      = ~w_sltsl_lvl & ~w_merq_lvl;
    assign w_wr_edge  = w_nwr_fall & w_acc;
    assign w_rd_edge  = w_nrd_fall & w_acc & ~w_nwr_fall;
    assign w_rd_abort = w_nrd_lvl | ~w_acc;
    assign w_mix      = {1'b0, left_in} + {1'b0, right_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_wrreq  <= 1'b0;
            r_rdreq  <= 1'b0;
            r_core_a <= '0;
            r_core_d <= '0;
            r_d_out  <= '0;
        end else begin
            r_wrreq <= 1'b0;
            r_rdreq <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_edge) begin
                        r_wrreq  <= 1'b1;
                        r_core_a <= slot_a;
                        r_core_d <= slot_d_in;
                        r_state  <= ST_WAIT_END;
                    end else if (w_rd_edge) begin
                        r_rdreq  <= 1'b1;
                        r_core_a <= slot_a;
                        r_timer  <= '0;
                        r_state  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (w_rd_abort) begin
                        r_state <= ST_IDLE;
                    end else if (core_q_valid) begin
                        r_d_out <= core_q;
                        r_state <= ST_RD_DRIVE;
                    end else if (r_timer == TMR_W'(RD_TIMEOUT)) begin
                        r_d_out <= OPEN_BUS;
                        r_state <= ST_RD_DRIVE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RD_DRIVE: begin
                    if (w_rd_abort) r_state <= ST_IDLE;
                end
                ST_WAIT_END: begin
                    if (w_nwr_lvl & w_nrd_lvl) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nint_oe <= 1'b0;
            r_left    <= '0;
            r_right   <= '0;
        end else begin
            r_nint_oe <= ~core_nint;
            if (sw_mono) begin
                r_left  <= f_scale(w_mix);
                r_right <= f_scale(w_mix);
            end else begin
                r_left  <= f_scale({left_in, 1'b0});
                r_right <= f_scale({right_in, 1'b0});
            end
        end
    end

    // Releases the pad in the very cycle the synchronised strobe or select goes inactive.
    assign slot_d_oe    = (r_state == ST_RD_DRIVE) & w_acc & ~w_nrd_lvl;
    assign slot_d_out   = r_d_out;
    assign slot_nint_oe = r_nint_oe;
    assign core_wrreq   = r_wrreq;
    assign core_rdreq   = r_rdreq;
    assign core_a       = r_core_a;
    assign core_d       = r_core_d;
    assign left_out     = r_left;
    assign right_out    = r_right;

endmodule
